wb_pipe_buf: RTL and testbench

- Parametrised write-back stage register with NUM_CH parallel result channels, replacing the single-channel MEM/WB latch.
- Sits between the memory stage and the register file.
- Each accepted bundle is buffered in a DEPTH-entry FIFO so the register-file write port can back-pressure without stalling the whole pipeline.
- Keeps the stall-vector bubble semantics; adds flush, x0 write suppression, intra-bundle conflict resolution and optional forwarding lookup.

---
 rtl/wb_pipe_buf_pkg.sv | 16 +
 rtl/wb_bundle_fifo.sv | 61 ++++++
 rtl/wb_pipe_buf.sv | 149 ++++++++++++++
 tb/tb_wb_pipe_buf.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pipe_buf_pkg.sv
// Shared constants for the write-back buffer: reset level, stall-vector bit
// positions and default widths.
package wb_pipe_buf_pkg;

    localparam logic        RstEnable  = 1'b1;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    localparam int STALL_SELF = 4;
    localparam int STALL_DOWN = 5;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/wb_bundle_fifo.sv
// Bundle storage for the write-back buffer: DEPTH slots, read/write pointers
// and occupancy count. Qualification of push/pop/clear is the wrapper's job.
module wb_bundle_fifo
    import wb_pipe_buf_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [DEPTH*WIDTH-1:0] entries,
    output logic [PTR_W-1:0]       rd_ptr,
    output logic [CNT_W-1:0]       count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in == RstEnable) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push && !clear)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

    always_comb begin
        entries = '0;
        for (int k = 0; k < DEPTH; k++)
            entries[k*WIDTH +: WIDTH] = mem[k];
    end

endmodule

// File: rtl/wb_pipe_buf.sv
// Multi-channel write-back stage buffer between MEM and the register file.
// Optional forwarding lookup over buffered entries is enabled by WB_FWD_EN.
module wb_pipe_buf
    import wb_pipe_buf_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int ADDR_W = DEF_ADDR_W,
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [5:0]               stall_in,
    input  logic                     flush_in,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_we,
    input  logic [NUM_CH*ADDR_W-1:0] in_addr,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     in_ready,
    input  logic                     wb_ready,
    output logic [NUM_CH-1:0]        wb_we,
    output logic [NUM_CH*ADDR_W-1:0] wb_addr,
    output logic [NUM_CH*DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]         count
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data
`endif
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int BUNDLE_W = NUM_CH * (1 + ADDR_W + DATA_W);
    localparam int ADDR_LO  = NUM_CH * DATA_W;
    localparam int WE_LO    = NUM_CH * (DATA_W + ADDR_W);

    logic                   push_ok;
    logic                   pop_ok;
    logic                   clear;
    logic [CNT_W-1:0]       count_next;
    logic [NUM_CH-1:0]      eff_we;
    logic                   overridden;
    logic [BUNDLE_W-1:0]    head;
    logic [DEPTH*BUNDLE_W-1:0] fifo_entries;
    logic [PTR_W-1:0]       rd_ptr;

    // A stalled stage inserts a bubble regardless of the downstream bit.
    assign push_ok = rdy_in & ~stall_in[STALL_SELF] & (|in_valid)
                   & (count < CNT_W'(DEPTH)) & ~flush_in;
    assign pop_ok  = rdy_in & (count != '0) & wb_ready & ~flush_in;
    assign clear   = rdy_in & flush_in;

    always_comb begin
        count_next = count;
        if (clear)
            count_next = '0;
        else if (push_ok && !pop_ok)
            count_next = count + 1'b1;
        else if (pop_ok && !push_ok)
            count_next = count - 1'b1;
    end

    // Effective write enables are resolved once at push time: x0 writes are
    // dropped and a higher channel to the same register overrides lower ones.
    always_comb begin
        eff_we     = '0;
        overridden = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            overridden = 1'b0;
            for (int j = i + 1; j < NUM_CH; j++) begin
                if (in_valid[j] && in_we[j] &&
                    in_addr[j*ADDR_W +: ADDR_W] == in_addr[i*ADDR_W +: ADDR_W])
                    overridden = 1'b1;
            end
            eff_we[i] = in_valid[i] & in_we[i]
                      & (in_addr[i*ADDR_W +: ADDR_W] != '0) & ~overridden;
        end
    end

    wb_bundle_fifo #(
        .WIDTH (BUNDLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push    (push_ok),
        .pop     (pop_ok),
        .clear   (clear),
        .wdata   ({eff_we, in_addr, in_data}),
        .rdata   (head),
        .entries (fifo_entries),
        .rd_ptr  (rd_ptr),
        .count   (count)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in == RstEnable)
            in_ready <= 1'b1;
        else if (rdy_in)
            in_ready <= (count_next < CNT_W'(DEPTH));
    end

    always_comb begin
        wb_we   = '0;
        wb_addr = '0;
        wb_data = '0;
        if (count != '0) begin
            wb_we   = head[WE_LO +: NUM_CH];
            wb_addr = head[ADDR_LO +: NUM_CH*ADDR_W];
            wb_data = head[0 +: NUM_CH*DATA_W];
        end
    end

    logic unused_stall;
    assign unused_stall = ^{stall_in[3:0], stall_in[STALL_DOWN]};

`ifdef WB_FWD_EN
    logic [PTR_W-1:0]    fwd_idx;
    logic [BUNDLE_W-1:0] fwd_entry;

    // Scan oldest to youngest so later matches (younger, higher channel) win.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_data  = '0;
        fwd_idx   = '0;
        fwd_entry = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx   = rd_ptr + PTR_W'(k);
            fwd_entry = fifo_entries[int'(fwd_idx)*BUNDLE_W +: BUNDLE_W];
            if (CNT_W'(k) < count) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (fwd_entry[WE_LO + ch] && fwd_addr != '0 &&
                        fwd_entry[ADDR_LO + ch*ADDR_W +: ADDR_W] == fwd_addr) begin
                        fwd_hit  = 1'b1;
                        fwd_data = fwd_entry[ch*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fifo_entries, rd_ptr};
`endif

endmodule

// File: tb/tb_wb_pipe_buf.sv
// Directed self-checking bench for wb_pipe_buf (default parameters); the
// forwarding checks are compiled in when WB_FWD_EN is defined.
module tb_wb_pipe_buf;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [5:0]  stall_in;
    logic        flush_in;
    logic [1:0]  in_valid;
    logic [1:0]  in_we;
    logic [9:0]  in_addr;
    logic [63:0] in_data;
    logic        in_ready;
    logic        wb_ready;
    logic [1:0]  wb_we;
    logic [9:0]  wb_addr;
    logic [63:0] wb_data;
    logic [2:0]  count;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    wb_pipe_buf dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .stall_in (stall_in),
        .flush_in (flush_in),
        .in_valid (in_valid),
        .in_we    (in_we),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wb_ready (wb_ready),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .count    (count)
`ifdef WB_FWD_EN
        ,
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] w,
                                 input logic [4:0] a0, input logic [4:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1);
        in_valid = v;
        in_we    = w;
        in_addr  = {a1, a0};
        in_data  = {d1, d0};
    endtask

    task automatic idle();
        applyStimulus(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    endtask

    // Inputs change at the falling edge; one step crosses one rising edge.
    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    initial begin
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        stall_in = 6'b0;
        flush_in = 1'b0;
        wb_ready = 1'b0;
        idle();
`ifdef WB_FWD_EN
        fwd_addr = 5'd0;
`endif
        @(negedge clk_in);
        @(negedge clk_in);
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_wb_we", 64'(wb_we), 64'd0);
        checkOutput("reset_wb_addr", 64'(wb_addr), 64'd0);
        checkOutput("reset_wb_data", wb_data, 64'd0);
        rst_in = 1'b0;

        // Single push with immediate drain
        wb_ready = 1'b1;
        applyStimulus(2'b01, 2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0);
        step();
        idle();
        checkOutput("single_we", 64'(wb_we), 64'b01);
        checkOutput("single_addr", 64'(wb_addr[4:0]), 64'd5);
        checkOutput("single_data", 64'(wb_data[31:0]), 64'hDEAD_BEEF);
        checkOutput("single_count", 64'(count), 64'd1);
        step();
        checkOutput("single_drained", 64'(count), 64'd0);
        checkOutput("single_we_off", 64'(wb_we), 64'd0);

        // Same destination on both channels: channel 1 wins
        wb_ready = 1'b0;
        applyStimulus(2'b11, 2'b11, 5'd7, 5'd7, 32'd1, 32'd2);
        step();
        idle();
        checkOutput("conflict_we", 64'(wb_we), 64'b10);
        checkOutput("conflict_data1", 64'(wb_data[63:32]), 64'd2);
        checkOutput("conflict_addr", 64'(wb_addr), 64'h0E7);
        wb_ready = 1'b1;
        step();
        checkOutput("conflict_drained", 64'(count), 64'd0);

        // Write to x0 is suppressed but the bundle is still buffered
        wb_ready = 1'b0;
        applyStimulus(2'b01, 2'b01, 5'd0, 5'd0, 32'h55, 32'h0);
        step();
        idle();
        checkOutput("x0_count", 64'(count), 64'd1);
        checkOutput("x0_we", 64'(wb_we), 64'd0);
        wb_ready = 1'b1;
        step();
        checkOutput("x0_drained", 64'(count), 64'd0);

        // Two independent writes
        wb_ready = 1'b0;
        applyStimulus(2'b11, 2'b11, 5'd3, 5'd4, 32'hA, 32'hB);
        step();
        checkOutput("dual_we", 64'(wb_we), 64'b11);
        checkOutput("dual_data", wb_data, 64'h0000_000B_0000_000A);

        // Simultaneous push and pop; invalid ch1 must not override ch0
        wb_ready = 1'b1;
        applyStimulus(2'b01, 2'b11, 5'd9, 5'd9, 32'hC, 32'hD);
        step();
        idle();
        checkOutput("pushpop_count", 64'(count), 64'd1);
        checkOutput("pushpop_we", 64'(wb_we), 64'b01);
        checkOutput("pushpop_addr", 64'(wb_addr[4:0]), 64'd9);
        checkOutput("pushpop_data", 64'(wb_data[31:0]), 64'hC);
        step();
        checkOutput("pushpop_drained", 64'(count), 64'd0);

        // Back-pressure fills the FIFO; a fifth push is ignored
        wb_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b01, 2'b01, 5'(10 + k), 5'd0, 32'(32'h100 + k), 32'h0);
            step();
        end
        checkOutput("full_count", 64'(count), 64'd4);
        checkOutput("full_in_ready", 64'(in_ready), 64'd0);
        applyStimulus(2'b01, 2'b01, 5'd31, 5'd0, 32'hBAD, 32'h0);
        step();
        idle();
        checkOutput("full_drop_count", 64'(count), 64'd4);
        checkOutput("full_drop_head", 64'(wb_addr[4:0]), 64'd10);
        wb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("drain_addr", 64'(wb_addr[4:0]), 64'(10 + k));
            checkOutput("drain_data", 64'(wb_data[31:0]), 64'(32'h100 + k));
            checkOutput("drain_count", 64'(count), 64'(4 - k));
            step();
        end
        checkOutput("drain_empty", 64'(count), 64'd0);
        checkOutput("drain_in_ready", 64'(in_ready), 64'd1);

        // Bubble, then hold with downstream stalled
        wb_ready = 1'b0;
        stall_in = 6'b010000;
        applyStimulus(2'b01, 2'b01, 5'd1, 5'd0, 32'd1, 32'd0);
        step();
        checkOutput("bubble_count", 64'(count), 64'd0);
        stall_in = 6'b000000;
        step();
        checkOutput("bubble_after", 64'(count), 64'd1);
        stall_in = 6'b110000;
        step();
        checkOutput("hold_count", 64'(count), 64'd1);
        stall_in = 6'b000000;

        // Flush overrides a concurrent push and pop
        applyStimulus(2'b01, 2'b01, 5'd2, 5'd0, 32'd2, 32'd0);
        step();
        checkOutput("preflush_count", 64'(count), 64'd2);
        flush_in = 1'b1;
        wb_ready = 1'b1;
        step();
        checkOutput("flush_count", 64'(count), 64'd0);
        checkOutput("flush_we", 64'(wb_we), 64'd0);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        flush_in = 1'b0;
        wb_ready = 1'b0;
        idle();

`ifdef WB_FWD_EN
        fwd_addr = 5'd3;
        #1;
        checkOutput("fwd_empty_hit", 64'(fwd_hit), 64'd0);
        applyStimulus(2'b01, 2'b01, 5'd3, 5'd0, 32'h11, 32'h0);
        step();
        applyStimulus(2'b11, 2'b11, 5'd6, 5'd3, 32'h99, 32'h22);
        step();
        applyStimulus(2'b01, 2'b01, 5'd8, 5'd0, 32'h88, 32'h0);
        step();
        idle();
        #1;
        checkOutput("fwd_young_hit", 64'(fwd_hit), 64'd1);
        checkOutput("fwd_young_data", 64'(fwd_data), 64'h22);
        fwd_addr = 5'd0;
        #1;
        checkOutput("fwd_x0_hit", 64'(fwd_hit), 64'd0);
        checkOutput("fwd_x0_data", 64'(fwd_data), 64'd0);
        fwd_addr = 5'd6;
        #1;
        checkOutput("fwd_ch0_data", 64'(fwd_data), 64'h99);
        fwd_addr = 5'd8;
        #1;
        checkOutput("fwd_tail_data", 64'(fwd_data), 64'h88);
        fwd_addr = 5'd9;
        #1;
        checkOutput("fwd_miss_hit", 64'(fwd_hit), 64'd0);
        fwd_addr = 5'd0;
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        checkOutput("fwd_flushed", 64'(count), 64'd0);
`endif

        // rdy_in low freezes pushes, pops and flushes
        applyStimulus(2'b01, 2'b01, 5'd12, 5'd0, 32'h12, 32'h0);
        step();
        applyStimulus(2'b01, 2'b01, 5'd13, 5'd0, 32'h13, 32'h0);
        step();
        rdy_in   = 1'b0;
        wb_ready = 1'b1;
        applyStimulus(2'b01, 2'b01, 5'd14, 5'd0, 32'h14, 32'h0);
        step();
        flush_in = 1'b1;
        step();
        checkOutput("freeze_count", 64'(count), 64'd2);
        checkOutput("freeze_head", 64'(wb_addr[4:0]), 64'd12);
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        wb_ready = 1'b0;
        applyStimulus(2'b01, 2'b01, 5'd15, 5'd0, 32'h15, 32'h0);
        step();
        idle();
        checkOutput("premid_count", 64'(count), 64'd3);

        // Asynchronous reset between edges
        rst_in = 1'b1;
        #1;
        checkOutput("async_we", 64'(wb_we), 64'd0);
        checkOutput("async_count", 64'(count), 64'd0);
        checkOutput("async_in_ready", 64'(in_ready), 64'd1);
        checkOutput("async_data", wb_data, 64'd0);
        #1;
        rst_in = 1'b0;
        step();
        checkOutput("post_reset_count", 64'(count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
